msrh_l2_req_arbiter: RTL and testbench

- Sits directly downstream of the tile's three L2 master ports: ICache refill, L1D external, and PTW.
- Merges them into one L2 request channel using round-robin arbitration, with a registered output slot.
- Tags each request with its source ID and routes L2 responses back to the originating port.
- Caps in-flight requests per source with an outstanding counter.

---
 rtl/msrh_pkg.sv | 28 ++
 rtl/msrh_rr_arbiter.sv | 48 ++++
 rtl/msrh_l2_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_msrh_l2_req_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrh_pkg.sv
// Shared L2 request arbiter types: source IDs, command encoding and the
// request bundle held in the arbiter output slot.
package msrh_pkg;

    localparam int L2_SRC_IC  = 0;
    localparam int L2_SRC_L1D = 1;
    localparam int L2_SRC_PTW = 2;
    localparam int L2_SRC_W   = 2;

    localparam int L2_ADDR_W = 56;
    localparam int L2_DATA_W = 512;
    localparam int L2_TAG_W  = 4;

    typedef enum logic [1:0] {
        L2_CMD_RD    = 2'd0,
        L2_CMD_WR    = 2'd1,
        L2_CMD_EVICT = 2'd2
    } l2_cmd_t;

    typedef struct packed {
        l2_cmd_t                       cmd;
        logic [L2_ADDR_W-1:0]          addr;
        logic [L2_SRC_W+L2_TAG_W-1:0]  tag;
        logic [L2_DATA_W-1:0]          data;
        logic [L2_DATA_W/8-1:0]        be;
    } l2_arb_req_t;

endpackage

// File: rtl/msrh_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// Ports: clk, rst_n, req (vector), en (grant allowed), grant (one-hot).
module msrh_rr_arbiter #(
    parameter int REQ_NUM = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] req,
    input  logic               en,
    output logic [REQ_NUM-1:0] grant
);

    localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two passes: requests at/after the pointer win, then wrap to the rest.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int j = 0; j < REQ_NUM; j++) begin
            if (en && !found && req[j] && j >= int'(ptr_q)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                ptr_d    = (j == REQ_NUM - 1) ? '0 : PW'(j + 1);
            end
        end
        for (int j = 0; j < REQ_NUM; j++) begin
            if (en && !found && req[j] && j < int'(ptr_q)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                ptr_d    = (j == REQ_NUM - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/msrh_l2_req_arbiter.sv
// Merges IC / L1D / PTW L2 requests into one registered channel, tags them
// with the source ID, routes responses back and caps in-flight per source.
// Ports: per-source req (valid/ready/payload), merged l2_req, l2_resp in,
// per-source resp out, o_err_bad_src pulse, o_perf_* counters.
// Macro MSRH_L2_ARB_PERF_EN enables the perf counters (else tied to 0).
module msrh_l2_req_arbiter
    import msrh_pkg::*;
#(
    parameter int SRC_NUM    = 3,
    parameter int ADDR_W     = L2_ADDR_W,
    parameter int DATA_W     = L2_DATA_W,
    parameter int TAG_W      = L2_TAG_W,
    parameter int OUTSTD_MAX = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset_n,
    input  logic [SRC_NUM-1:0]                    i_src_req_valid,
    output logic [SRC_NUM-1:0]                    o_src_req_ready,
    input  logic [SRC_NUM-1:0][1:0]               i_src_req_cmd,
    input  logic [SRC_NUM-1:0][ADDR_W-1:0]        i_src_req_addr,
    input  logic [SRC_NUM-1:0][TAG_W-1:0]         i_src_req_tag,
    input  logic [SRC_NUM-1:0][DATA_W-1:0]        i_src_req_data,
    input  logic [SRC_NUM-1:0][DATA_W/8-1:0]      i_src_req_be,
    output logic                                  o_l2_req_valid,
    input  logic                                  i_l2_req_ready,
    output logic [1:0]                            o_l2_req_cmd,
    output logic [ADDR_W-1:0]                     o_l2_req_addr,
    output logic [DATA_W-1:0]                     o_l2_req_data,
    output logic [DATA_W/8-1:0]                   o_l2_req_be,
    output logic [TAG_W+1:0]                      o_l2_req_tag,
    input  logic                                  i_l2_resp_valid,
    output logic                                  o_l2_resp_ready,
    input  logic [TAG_W+1:0]                      i_l2_resp_tag,
    input  logic [DATA_W-1:0]                     i_l2_resp_data,
    output logic [SRC_NUM-1:0]                    o_src_resp_valid,
    input  logic [SRC_NUM-1:0]                    i_src_resp_ready,
    output logic [TAG_W-1:0]                      o_src_resp_tag,
    output logic [DATA_W-1:0]                     o_src_resp_data,
    output logic                                  o_err_bad_src,
    output logic [SRC_NUM-1:0][31:0]              o_perf_grant,
    output logic [SRC_NUM-1:0][31:0]              o_perf_stall
);

    localparam int CW = $clog2(OUTSTD_MAX + 1);

    logic                        slot_valid_q;
    l2_arb_req_t                 slot_q;
    l2_arb_req_t                 req_d;
    logic                        slot_free;
    logic [SRC_NUM-1:0]          eligible;
    logic [SRC_NUM-1:0]          grant;
    logic [SRC_NUM-1:0][CW-1:0]  cnt_q;
    logic [SRC_NUM-1:0]          resp_hs;
    logic [L2_SRC_W-1:0]         resp_src;
    logic                        bad_src;
    logic                        err_q;

    // A full slot being drained this cycle can be refilled in the same cycle.
    assign slot_free = !slot_valid_q || i_l2_req_ready;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            eligible[i] = i_src_req_valid[i] && (cnt_q[i] < CW'(OUTSTD_MAX));
        end
    end

    msrh_rr_arbiter #(
        .REQ_NUM (SRC_NUM)
    ) u_rr (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .req   (eligible),
        .en    (slot_free),
        .grant (grant)
    );

    assign o_src_req_ready = grant;

    always_comb begin
        req_d = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (grant[i]) begin
                req_d.cmd  = l2_cmd_t'(i_src_req_cmd[i]);
                req_d.addr = i_src_req_addr[i];
                req_d.tag  = {L2_SRC_W'(i), i_src_req_tag[i]};
                req_d.data = i_src_req_data[i];
                req_d.be   = i_src_req_be[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
        end else if (slot_free) begin
            slot_valid_q <= |grant;
            if (|grant) begin
                slot_q <= req_d;
            end
        end
    end

    assign o_l2_req_valid = slot_valid_q;
    assign o_l2_req_cmd   = slot_q.cmd;
    assign o_l2_req_addr  = slot_q.addr;
    assign o_l2_req_data  = slot_q.data;
    assign o_l2_req_be    = slot_q.be;
    assign o_l2_req_tag   = slot_q.tag;

    // Response routing; an unknown source is accepted and dropped.
    assign resp_src = i_l2_resp_tag[TAG_W +: L2_SRC_W];
    assign bad_src  = int'(resp_src) >= SRC_NUM;

    always_comb begin
        o_src_resp_valid = '0;
        o_l2_resp_ready  = bad_src;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (resp_src == L2_SRC_W'(i)) begin
                o_src_resp_valid[i] = i_l2_resp_valid;
                o_l2_resp_ready     = i_src_resp_ready[i];
            end
        end
    end

    assign resp_hs         = o_src_resp_valid & i_src_resp_ready;
    assign o_src_resp_tag  = i_l2_resp_tag[TAG_W-1:0];
    assign o_src_resp_data = i_l2_resp_data;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                case ({grant[i], resp_hs[i]})
                    2'b10: cnt_q[i] <= cnt_q[i] + CW'(1);
                    2'b01: begin
                        // Late responses after a reset saturate at zero.
                        if (cnt_q[i] != '0) begin
                            cnt_q[i] <= cnt_q[i] - CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            for (int i = 0; i < SRC_NUM; i++) begin
                assert (!(resp_hs[i] && !grant[i] && cnt_q[i] == '0));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= i_l2_resp_valid && bad_src;
        end
    end

    assign o_err_bad_src = err_q;

`ifdef MSRH_L2_ARB_PERF_EN
    logic [SRC_NUM-1:0][31:0] perf_grant_q;
    logic [SRC_NUM-1:0][31:0] perf_stall_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (grant[i] && perf_grant_q[i] != '1) begin
                    perf_grant_q[i] <= perf_grant_q[i] + 32'd1;
                end
                if (i_src_req_valid[i] && !grant[i] && perf_stall_q[i] != '1) begin
                    perf_stall_q[i] <= perf_stall_q[i] + 32'd1;
                end
            end
        end
    end

    assign o_perf_grant = perf_grant_q;
    assign o_perf_stall = perf_stall_q;
`else
    assign o_perf_grant = '0;
    assign o_perf_stall = '0;
`endif

endmodule

// File: tb/tb_msrh_l2_req_arbiter.sv
// Directed testbench for msrh_l2_req_arbiter: round-robin order, outstanding
// caps, slot hold, response routing, bad source and asynchronous reset.
module tb_msrh_l2_req_arbiter;

    localparam int SN = 3;
    localparam int AW = 56;
    localparam int DW = 512;
    localparam int TW = 4;
    localparam int BW = DW / 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [SN-1:0]          src_req_valid = '0;
    logic [SN-1:0]          src_req_ready;
    logic [SN-1:0][1:0]     src_req_cmd = '0;
    logic [SN-1:0][AW-1:0]  src_req_addr = '0;
    logic [SN-1:0][TW-1:0]  src_req_tag = '0;
    logic [SN-1:0][DW-1:0]  src_req_data = '0;
    logic [SN-1:0][BW-1:0]  src_req_be = '0;
    logic                   l2_req_valid;
    logic                   l2_req_ready = 1'b1;
    logic [1:0]             l2_req_cmd;
    logic [AW-1:0]          l2_req_addr;
    logic [DW-1:0]          l2_req_data;
    logic [BW-1:0]          l2_req_be;
    logic [TW+1:0]          l2_req_tag;
    logic                   l2_resp_valid = 1'b0;
    logic                   l2_resp_ready;
    logic [TW+1:0]          l2_resp_tag = '0;
    logic [DW-1:0]          l2_resp_data = '0;
    logic [SN-1:0]          src_resp_valid;
    logic [SN-1:0]          src_resp_ready = '0;
    logic [TW-1:0]          src_resp_tag;
    logic [DW-1:0]          src_resp_data;
    logic                   err_bad_src;
    logic [SN-1:0][31:0]    perf_grant;
    logic [SN-1:0][31:0]    perf_stall;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    msrh_l2_req_arbiter dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_src_req_valid  (src_req_valid),
        .o_src_req_ready  (src_req_ready),
        .i_src_req_cmd    (src_req_cmd),
        .i_src_req_addr   (src_req_addr),
        .i_src_req_tag    (src_req_tag),
        .i_src_req_data   (src_req_data),
        .i_src_req_be     (src_req_be),
        .o_l2_req_valid   (l2_req_valid),
        .i_l2_req_ready   (l2_req_ready),
        .o_l2_req_cmd     (l2_req_cmd),
        .o_l2_req_addr    (l2_req_addr),
        .o_l2_req_data    (l2_req_data),
        .o_l2_req_be      (l2_req_be),
        .o_l2_req_tag     (l2_req_tag),
        .i_l2_resp_valid  (l2_resp_valid),
        .o_l2_resp_ready  (l2_resp_ready),
        .i_l2_resp_tag    (l2_resp_tag),
        .i_l2_resp_data   (l2_resp_data),
        .o_src_resp_valid (src_resp_valid),
        .i_src_resp_ready (src_resp_ready),
        .o_src_resp_tag   (src_resp_tag),
        .o_src_resp_data  (src_resp_data),
        .o_err_bad_src    (err_bad_src),
        .o_perf_grant     (perf_grant),
        .o_perf_stall     (perf_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        src_req_valid  = '0;
        l2_resp_valid  = 1'b0;
        src_resp_ready = '0;
        l2_req_ready   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic set_src(input int s, input logic [TW-1:0] t,
                           input logic [AW-1:0] a);
        src_req_cmd[s]  = 2'(s);
        src_req_tag[s]  = t;
        src_req_addr[s] = a;
        src_req_data[s] = {16{a[31:0]}};
        src_req_be[s]   = 64'h0F0F_0000_FFFF_0001 << s;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_vld", l2_req_valid, 0);
        chk("rst_tag", l2_req_tag, 0);
        chk("rst_addr", l2_req_addr, 0);
        chk("rst_err", err_bad_src, 0);
        rst_n = 1'b1;
        tick();

        // 1: all sources valid, L2 always ready -> IC, L1D, PTW, ...
        set_src(0, 4'h1, 56'h1000);
        set_src(1, 4'h2, 56'h2000);
        set_src(2, 4'h3, 56'h3000);
        src_req_valid = 3'b111;
        settle();
        for (int k = 0; k < 6; k++) begin
            chk("t1_gnt", src_req_ready, 64'(3'b001 << (k % 3)));
            if (k > 0) begin
                chk("t1_vld", l2_req_valid, 1);
                chk("t1_tag", l2_req_tag,
                    {2'((k - 1) % 3), 4'((k - 1) % 3 + 1)});
                chk("t1_addr", l2_req_addr,
                    64'(((k - 1) % 3 + 1) * 32'h1000));
                chk("t1_cmd", l2_req_cmd, 64'((k - 1) % 3));
                chk("t1_data", l2_req_data[63:0],
                    {2{32'(((k - 1) % 3 + 1) * 32'h1000)}});
            end
            tick();
        end
        src_req_valid = '0;
        settle();
        chk("t1_last_tag", l2_req_tag, 6'h23);
        chk("t1_last_be", l2_req_be, 64'h0F0F_0000_FFFF_0001 << 2);
        tick();
        chk("t1_drain", l2_req_valid, 0);

        // 2: L1D capped at 4 outstanding, others still served
        do_reset();
        set_src(1, 4'h3, 56'h4000);
        src_req_valid = 3'b010;
        settle();
        for (int k = 0; k < 4; k++) begin
            chk("t2_gnt", src_req_ready, 3'b010);
            tick();
            chk("t2_tag", l2_req_tag, 6'h13);
        end
        chk("t2_stall", src_req_ready, 0);
        src_req_valid = 3'b111;
        settle();
        chk("t2_oth_a", src_req_ready, 3'b100);
        tick();
        chk("t2_oth_b", src_req_ready, 3'b001);
        tick();
        chk("t2_oth_c", src_req_ready, 3'b100);
        src_req_valid  = 3'b010;
        l2_resp_valid  = 1'b1;
        l2_resp_tag    = 6'h13;
        l2_resp_data   = {8{64'hCAFE_0000_1234_5678}};
        src_resp_ready = 3'b010;
        settle();
        chk("t2_still", src_req_ready, 0);
        chk("t2_rvld", src_resp_valid, 3'b010);
        chk("t2_rrdy", l2_resp_ready, 1);
        chk("t2_rtag", src_resp_tag, 4'h3);
        chk("t2_rdata", src_resp_data[63:0], 64'hCAFE_0000_1234_5678);
        tick();
        l2_resp_valid  = 1'b0;
        src_resp_ready = '0;
        settle();
        chk("t2_regnt", src_req_ready, 3'b010);
        src_req_valid = '0;
        settle();

        // 3: L2 back-pressure holds the slot, then drain+refill
        do_reset();
        l2_req_ready = 1'b0;
        set_src(0, 4'h5, 56'hA0);
        src_req_valid = 3'b001;
        settle();
        chk("t3_gnt", src_req_ready, 3'b001);
        tick();
        set_src(0, 4'h6, 56'hA1);
        set_src(1, 4'h9, 56'hB9);
        src_req_valid = 3'b011;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("t3_hvld", l2_req_valid, 1);
            chk("t3_haddr", l2_req_addr, 56'hA0);
            chk("t3_htag", l2_req_tag, 6'h05);
            chk("t3_hgnt", src_req_ready, 0);
            tick();
        end
        l2_req_ready  = 1'b1;
        src_req_valid = 3'b001;
        settle();
        chk("t3_rgnt", src_req_ready, 3'b001);
        tick();
        chk("t3_nvld", l2_req_valid, 1);
        chk("t3_naddr", l2_req_addr, 56'hA1);
        chk("t3_ntag", l2_req_tag, 6'h06);
        src_req_valid = '0;
        tick();
        chk("t3_drain", l2_req_valid, 0);

        // 4: PTW response held off by the source
        do_reset();
        set_src(2, 4'h5, 56'hB0);
        src_req_valid = 3'b100;
        settle();
        for (int k = 0; k < 4; k++) begin
            chk("t4_gnt", src_req_ready, 3'b100);
            tick();
        end
        chk("t4_cap", src_req_ready, 0);
        l2_resp_valid  = 1'b1;
        l2_resp_tag    = 6'h25;
        src_resp_ready = '0;
        settle();
        chk("t4_rrdy0", l2_resp_ready, 0);
        chk("t4_rvld", src_resp_valid, 3'b100);
        tick();
        chk("t4_rrdy1", l2_resp_ready, 0);
        chk("t4_cnt_hold", src_req_ready, 0);
        src_resp_ready = 3'b100;
        settle();
        chk("t4_rrdy2", l2_resp_ready, 1);
        chk("t4_rtag", src_resp_tag, 4'h5);
        tick();
        l2_resp_valid  = 1'b0;
        src_resp_ready = '0;
        settle();
        chk("t4_dec", src_req_ready, 3'b100);
        src_req_valid = '0;
        settle();

        // 5: bad source ID dropped with one error pulse
        l2_resp_valid = 1'b1;
        l2_resp_tag   = 6'h31;
        settle();
        chk("t5_rrdy", l2_resp_ready, 1);
        chk("t5_rvld", src_resp_valid, 0);
        chk("t5_err0", err_bad_src, 0);
        tick();
        l2_resp_valid = 1'b0;
        settle();
        chk("t5_err1", err_bad_src, 1);
        tick();
        chk("t5_err2", err_bad_src, 0);
        src_req_valid = 3'b100;
        settle();
        chk("t5_cnt_a", src_req_ready, 3'b100);
        tick();
        chk("t5_cnt_b", src_req_ready, 0);
        src_req_valid = '0;
        settle();

        // 6: grant and response to IC together, then async reset
        do_reset();
        set_src(0, 4'h7, 56'hC0);
        src_req_valid = 3'b001;
        settle();
        for (int k = 0; k < 3; k++) begin
            chk("t6_gnt", src_req_ready, 3'b001);
            tick();
        end
        l2_resp_valid  = 1'b1;
        l2_resp_tag    = 6'h07;
        src_resp_ready = 3'b001;
        settle();
        chk("t6_both_g", src_req_ready, 3'b001);
        chk("t6_both_r", src_resp_valid, 3'b001);
        tick();
        l2_resp_valid  = 1'b0;
        src_resp_ready = '0;
        settle();
        chk("t6_cnt3", src_req_ready, 3'b001);
        tick();
        chk("t6_cnt4", src_req_ready, 0);
        set_src(1, 4'h1, 56'hD1);
        set_src(2, 4'h2, 56'hD2);
        src_req_valid = 3'b111;
        settle();
        chk("t6_b0", src_req_ready, 3'b010);
        tick();
        chk("t6_b1", src_req_ready, 3'b100);
        tick();
        chk("t6_b2", src_req_ready, 3'b010);
        chk("t6_pre_vld", l2_req_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", l2_req_valid, 0);
        chk("t6_rst_tag", l2_req_tag, 0);
        chk("t6_rst_addr", l2_req_addr, 0);
        chk("t6_rst_err", err_bad_src, 0);
        rst_n = 1'b1;
        settle();
        chk("t6_post_gnt", src_req_ready, 3'b001);
        tick();
        chk("t6_post_vld", l2_req_valid, 1);
        chk("t6_post_tag", l2_req_tag, 6'h07);
        src_req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
